semaforo_multi: RTL and testbench
=================================

# semaforo_multi

Parametrised traffic-light controller for N_DIR conflicting approaches, the next generation of the single-approach semaforo. It rotates right-of-way green → yellow → all-red across the approaches, with per-phase durations set by parameters. It adds an optional pedestrian walk phase and a hold input. It sits directly on the system clock and drives lamp outputs.

## Interface
- N_DIR, 2, number of approaches (≥2)
- GREEN_CYC, 8, green duration in clk cycles (≥1)
- YELLOW_CYC, 2, yellow duration in cycles (≥1)
- ALLRED_CYC, 1, all-red clearance duration in cycles (≥1)
- WALK_CYC, 4, pedestrian walk duration in cycles (≥1)
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low
- hold  in  1  freeze phase counter while high
- ped_req  in  1  pedestrian request; a single-cycle pulse suffices
- green  out  N_DIR  one-hot green lamp per approach
- yellow  out  N_DIR  one-hot yellow lamp per approach
- red  out  N_DIR  red lamp per approach
- walk  out  1  pedestrian walk lamp
- dir  out  $clog2(N_DIR)  index of approach currently owning / last owning right-of-way

## Operation
- States: GREEN, YELLOW, ALLRED, WALK.
- Reset (rst=0) is asynchronous. It forces state=ALLRED, dir=N_DIR-1, cnt=ALLRED_CYC-1, ped_pending=0. Outputs: green=0, yellow=0, red=all 1s, walk=0.
- Phase counter: on entry, cnt is loaded with duration-1. It decrements once per cycle while hold=0. The transition happens on the edge where cnt==0 and hold=0. Each phase therefore lasts exactly its duration plus the number of held cycles.
- Transitions:
  - GREEN→YELLOW.
  - YELLOW→ALLRED.
  - ALLRED→WALK if ped_pending (PED feature compiled in).
  - Otherwise ALLRED→GREEN with dir=(dir+1) mod N_DIR.
  - WALK→GREEN with dir=(dir+1) mod N_DIR.
- dir wraps from N_DIR-1 to 0. Its width is $clog2(N_DIR).
- Lamp outputs are decoded from registered state and dir only; they are glitch-free Moore outputs.
  - GREEN: green[dir]=1, red=all 1s except bit dir.
  - YELLOW: yellow[dir]=1, red=all 1s except bit dir.
  - ALLRED and WALK: red=all 1s.
  - walk=1 only in WALK.
- Exactly one of green[i], yellow[i], red[i] is 1 for every approach i at all times.
- ped_pending is a sticky register, set by ped_req=1 on any edge.
  - It is cleared on the edge entering WALK.
  - If ped_req=1 on that same edge, the clear wins and the request is absorbed.
  - ped_req during WALK re-arms ped_pending, so a walk is served on the next all-red.
- hold=1 freezes cnt and state in any phase, including WALK. ped_req is still latched while hold=1.

## Timing
- No combinational path from inputs to outputs. All outputs change only on a clk rising edge or on assertion of rst.
- After rst deasserts, GREEN for dir 0 begins ALLRED_CYC edges later.
- Full rotation without walk: N_DIR·(GREEN_CYC+YELLOW_CYC+ALLRED_CYC) cycles. Each serviced walk adds WALK_CYC cycles.
- Reset mid-phase: lamps go immediately to all-red and the pending request is lost.

## Configuration
- SEMAFORO_PED_EN defined: ped_pending register, WALK state and walk output logic are present.
- SEMAFORO_PED_EN undefined:
  - WALK state and ped_pending are removed; ped_req is ignored.
  - walk is tied to 0.
  - ALLRED always proceeds to GREEN. WALK_CYC is unused.

## Structure
- The shared package semaforo_pkg holds:
  - the state enum typedef (GREEN, YELLOW, ALLRED, WALK);
  - the lamp-vector decode function.
- One sub-module: semaforo_timer.
  - Contains the loadable down-counter with hold and a done flag.
  - Width = $clog2(max duration)+1.
  - Instantiated once.

## Test plan
- Defaults, reset pulse then run 30 cycles:
  - red=2'b11 during reset;
  - dir 0 sequence: green 8 → yellow 2 → all-red 1;
  - then green[1];
  - dir 0 green re-enters at cycle 23 (period 22).
- PED_EN build, ped_req pulse during green[0]:
  - after the 1-cycle all-red, walk=1 for 4 cycles with red=2'b11;
  - then green[1]; that round's period is 26.
- hold=1 for 5 cycles mid green[0]: green lasts 13 cycles, and the rest of the sequence is unchanged.
- rst=0 asserted mid-yellow (between edges): yellow=0 and red=2'b11 immediately. After release, green[0] follows after 1 cycle.
- ped_req on the WALK-entry edge and again during WALK:
  - the first request is absorbed;
  - the second yields exactly one more walk on the next all-red.
  - Non-PED build: walk stays 0 throughout.
- N_DIR=3: dir rotates 0→1→2→0. The one-lamp-per-approach invariant is asserted every cycle.

Source files
------------

// File: rtl/semaforo_pkg.sv
// semaforo_pkg: shared phase encoding and per-approach lamp decode for semaforo_multi.
package semaforo_pkg;

    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        YELLOW = 2'd1,
        ALLRED = 2'd2,
        WALK   = 2'd3
    } phase_t;

    typedef struct packed {
        logic green;
        logic yellow;
        logic red;
    } lamp_t;

    // Lamp for one approach: the owner shows green/yellow in those phases, all others red.
    function automatic lamp_t lamp_decode(input phase_t ph, input logic owner);
        lamp_t l;
        l.green  = 1'b0;
        l.yellow = 1'b0;
        l.red    = 1'b1;
        if (owner && ph == GREEN) begin
            l.green = 1'b1;
            l.red   = 1'b0;
        end else if (owner && ph == YELLOW) begin
            l.yellow = 1'b1;
            l.red    = 1'b0;
        end
        return l;
    endfunction

    // Longest phase duration, used to size the phase counter.
    function automatic int unsigned max_dur(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/semaforo_timer.sv
// semaforo_timer: loadable phase down-counter with hold; done_c flags a count of zero.
module semaforo_timer
    import semaforo_pkg::*;
#(
    parameter int unsigned CW      = 4,
    parameter int unsigned RST_VAL = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hold,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          done_c
);

    logic [CW-1:0] cnt;

    // Load on phase change, otherwise count down unless frozen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= CW'(RST_VAL);
        end else if (load) begin
            cnt <= load_val;
        end else if (!hold && cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign done_c = (cnt == '0);

endmodule

// File: rtl/semaforo_multi.sv
// semaforo_multi: N_DIR-approach traffic-light controller (green -> yellow -> all-red rotation).
// Optional pedestrian walk phase is compiled in with the SEMAFORO_PED_EN macro.
module semaforo_multi
    import semaforo_pkg::*;
#(
    parameter int unsigned N_DIR      = 2,
    parameter int unsigned GREEN_CYC  = 8,
    parameter int unsigned YELLOW_CYC = 2,
    parameter int unsigned ALLRED_CYC = 1,
    parameter int unsigned WALK_CYC   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     hold,
    input  logic                     ped_req,
    output logic [N_DIR-1:0]         green,
    output logic [N_DIR-1:0]         yellow,
    output logic [N_DIR-1:0]         red,
    output logic                     walk,
    output logic [$clog2(N_DIR)-1:0] dir
);

    localparam int unsigned DW   = $clog2(N_DIR);
    localparam int unsigned MAXD = max_dur(GREEN_CYC, YELLOW_CYC, ALLRED_CYC, WALK_CYC);
    localparam int unsigned CW   = $clog2(MAXD) + 1;

    phase_t             state;
    phase_t             nxt_state;
    logic               ped_c;
    logic               done_c;
    logic               load_c;
    logic [DW-1:0]      dir_inc;
    logic [DW-1:0]      dir_new;
    logic [CW-1:0]      load_val;
    logic [N_DIR-1:0]   green_c;
    logic [N_DIR-1:0]   yellow_c;
    logic [N_DIR-1:0]   red_c;

    // Phase successor; a pending pedestrian request diverts all-red into walk.
    function automatic phase_t next_phase(input phase_t s, input logic ped);
        case (s)
            GREEN:   return YELLOW;
            YELLOW:  return ALLRED;
            ALLRED:  return ped ? WALK : GREEN;
            default: return GREEN;
        endcase
    endfunction

    // Counter reload value (duration-1) for the phase being entered.
    function automatic logic [CW-1:0] phase_len(input phase_t s);
        case (s)
            GREEN:   return CW'(GREEN_CYC - 1);
            YELLOW:  return CW'(YELLOW_CYC - 1);
            ALLRED:  return CW'(ALLRED_CYC - 1);
            default: return CW'(WALK_CYC - 1);
        endcase
    endfunction

    semaforo_timer #(
        .CW      (CW),
        .RST_VAL (ALLRED_CYC - 1)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .hold     (hold),
        .load     (load_c),
        .load_val (load_val),
        .done_c   (done_c)
    );

    assign load_c    = done_c & ~hold;
    assign nxt_state = next_phase(state, ped_c);
    assign load_val  = phase_len(nxt_state);
    assign dir_inc   = (dir == DW'(N_DIR - 1)) ? '0 : dir + DW'(1);
    assign dir_new   = (nxt_state == GREEN) ? dir_inc : dir;

    // Lamp pattern for the upcoming phase, registered below so outputs stay Moore.
    for (genvar i = 0; i < N_DIR; i++) begin : g_lamp
        lamp_t l_c;
        assign l_c         = lamp_decode(nxt_state, dir_new == DW'(i));
        assign green_c[i]  = l_c.green;
        assign yellow_c[i] = l_c.yellow;
        assign red_c[i]    = l_c.red;
    end

    // Phase register, right-of-way owner and registered lamps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ALLRED;
            dir    <= DW'(N_DIR - 1);
            green  <= '0;
            yellow <= '0;
            red    <= '1;
        end else if (load_c) begin
            state  <= nxt_state;
            dir    <= dir_new;
            green  <= green_c;
            yellow <= yellow_c;
            red    <= red_c;
        end
    end

`ifdef SEMAFORO_PED_EN
    logic ped_pending;

    // Sticky request; the clear on walk entry wins over a same-edge request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ped_pending <= 1'b0;
        end else if (load_c && nxt_state == WALK) begin
            ped_pending <= 1'b0;
        end else if (ped_req) begin
            ped_pending <= 1'b1;
        end
    end

    // Walk lamp follows the walk phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            walk <= 1'b0;
        end else if (load_c) begin
            walk <= (nxt_state == WALK);
        end
    end

    assign ped_c = ped_pending;
`else
    logic unused_ped_req;

    assign unused_ped_req = ped_req;
    assign ped_c          = 1'b0;
    assign walk           = 1'b0;
`endif

endmodule

// File: tb/tb_semaforo_multi.sv
// tb_semaforo_multi: table vectors, directed corner sequences and random run against a phase model.
module tb_semaforo_multi;

`ifdef SEMAFORO_PED_EN
    localparam bit PED = 1'b1;
`else
    localparam bit PED = 1'b0;
`endif

    localparam int PH_G = 0;
    localparam int PH_Y = 1;
    localparam int PH_A = 2;
    localparam int PH_W = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hold = 1'b0;
    logic ped_req = 1'b0;

    logic [1:0] g2, y2, r2;
    logic       w2;
    logic [0:0] d2;
    logic [2:0] g3, y3, r3;
    logic       w3;
    logic [1:0] d3;

    semaforo_multi u_dut2 (
        .clk(clk), .rst(rst), .hold(hold), .ped_req(ped_req),
        .green(g2), .yellow(y2), .red(r2), .walk(w2), .dir(d2)
    );

    semaforo_multi #(
        .N_DIR(3), .GREEN_CYC(3), .YELLOW_CYC(1), .ALLRED_CYC(2), .WALK_CYC(2)
    ) u_dut3 (
        .clk(clk), .rst(rst), .hold(hold), .ped_req(ped_req),
        .green(g3), .yellow(y3), .red(r3), .walk(w3), .dir(d3)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ph;
        int dir;
        int rem;
        bit ped;
        int n;
        int dg, dy, da, dw;
    } model_t;

    typedef struct {
        bit          h;
        bit          p;
        int          ncyc;
        logic [31:0] exp;
    } vec_t;

    int     checks = 0;
    int     failures = 0;
    model_t m2, m3;
    int     q3[$];
    logic [2:0] prev_g3;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pk(input logic [31:0] g, input logic [31:0] y,
                                       input logic [31:0] r, input logic w, input logic [31:0] d);
        return (32'(w) << 24) | (d << 16) | (r << 8) | (y << 4) | g;
    endfunction

    function automatic model_t mreset(input int n, input int dg, input int dy, input int da, input int dw);
        model_t m;
        m.ph = PH_A; m.dir = n - 1; m.rem = da; m.ped = 1'b0; m.n = n;
        m.dg = dg; m.dy = dy; m.da = da; m.dw = dw;
        return m;
    endfunction

    function automatic int mdur(input model_t m, input int ph);
        case (ph)
            PH_G:    return m.dg;
            PH_Y:    return m.dy;
            PH_A:    return m.da;
            default: return m.dw;
        endcase
    endfunction

    // One clock edge of the traffic rules: rem counts the cycles left in the phase.
    function automatic model_t mstep(input model_t m, input bit h, input bit p);
        model_t r;
        bit into_walk;
        r = m;
        into_walk = 1'b0;
        if (!h) begin
            if (m.rem > 1) begin
                r.rem = m.rem - 1;
            end else begin
                case (m.ph)
                    PH_G: r.ph = PH_Y;
                    PH_Y: r.ph = PH_A;
                    PH_A: begin
                        if (PED && m.ped) begin
                            r.ph = PH_W;
                            into_walk = 1'b1;
                        end else begin
                            r.ph = PH_G;
                            r.dir = (m.dir + 1) % m.n;
                        end
                    end
                    default: begin
                        r.ph = PH_G;
                        r.dir = (m.dir + 1) % m.n;
                    end
                endcase
                r.rem = mdur(r, r.ph);
            end
        end
        if (into_walk) r.ped = 1'b0;
        else if (PED && p) r.ped = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] mpk(input model_t m);
        logic [31:0] g, y, r;
        g = (m.ph == PH_G) ? (32'd1 << m.dir) : 32'd0;
        y = (m.ph == PH_Y) ? (32'd1 << m.dir) : 32'd0;
        r = ((32'd1 << m.n) - 32'd1) & ~(g | y);
        return pk(g, y, r, m.ph == PH_W, 32'(m.dir));
    endfunction

    function automatic logic [31:0] inv_ok(input logic [31:0] g, input logic [31:0] y,
                                           input logic [31:0] r, input int n);
        for (int i = 0; i < n; i++)
            if ((32'(g[i]) + 32'(y[i]) + 32'(r[i])) != 32'd1) return 32'd0;
        return 32'd1;
    endfunction

    task automatic tick(input bit h, input bit p);
        hold = h;
        ped_req = p;
        @(posedge clk);
        m2 = mstep(m2, h, p);
        m3 = mstep(m3, h, p);
        @(negedge clk);
        chk("model2", pk(32'(g2), 32'(y2), 32'(r2), w2, 32'(d2)), mpk(m2));
        chk("model3", pk(32'(g3), 32'(y3), 32'(r3), w3, 32'(d3)), mpk(m3));
        chk("onelamp2", inv_ok(32'(g2), 32'(y2), 32'(r2), 2), 32'd1);
        chk("onelamp3", inv_ok(32'(g3), 32'(y3), 32'(r3), 3), 32'd1);
        if (g3 != 3'd0 && prev_g3 == 3'd0) q3.push_back(int'(d3));
        prev_g3 = g3;
        hold = 1'b0;
        ped_req = 1'b0;
    endtask

    // Assert reset between edges and check the lamps fall to all-red at once.
    task automatic do_reset();
        hold = 1'b0;
        ped_req = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("rst_lamps2", pk(32'(g2), 32'(y2), 32'(r2), w2, 32'(d2)), pk(0, 0, 3, 0, 1));
        chk("rst_lamps3", pk(32'(g3), 32'(y3), 32'(r3), w3, 32'(d3)), pk(0, 0, 7, 0, 2));
        m2 = mreset(2, 8, 2, 1, 4);
        m3 = mreset(3, 3, 1, 2, 2);
        q3.delete();
        prev_g3 = 3'd0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_to_allred();
        bit reached;
        reached = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (m2.ph == PH_A && m2.rem == 1) begin
                reached = 1'b1;
                break;
            end
            tick(0, 0);
        end
        chk("reach_allred", 32'(reached), 32'd1);
    endtask

    task automatic count_walks(input int ncyc, input int start, output int walks);
        logic prev;
        walks = start;
        prev = w2;
        for (int k = 0; k < ncyc; k++) begin
            tick(0, 0);
            if (w2 && !prev) walks++;
            prev = w2;
        end
    endtask

    initial begin
        vec_t tbl[7];
        int   cnt, cyc, walks, got0, got1, exp_dir;
        bit   done;

        tbl[0] = '{h: 1'b0, p: 1'b0, ncyc: 8, exp: pk(1, 0, 2, 0, 0)};
        tbl[1] = '{h: 1'b0, p: 1'b0, ncyc: 2, exp: pk(0, 1, 2, 0, 0)};
        tbl[2] = '{h: 1'b0, p: 1'b0, ncyc: 1, exp: pk(0, 0, 3, 0, 0)};
        tbl[3] = '{h: 1'b0, p: 1'b0, ncyc: 8, exp: pk(2, 0, 1, 0, 1)};
        tbl[4] = '{h: 1'b0, p: 1'b0, ncyc: 2, exp: pk(0, 2, 1, 0, 1)};
        tbl[5] = '{h: 1'b0, p: 1'b0, ncyc: 1, exp: pk(0, 0, 3, 0, 1)};
        tbl[6] = '{h: 1'b0, p: 1'b0, ncyc: 1, exp: pk(1, 0, 2, 0, 0)};

        @(negedge clk);
        do_reset();

        // Default rotation from reset: period 22, dir 0 green again on edge 23.
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < tbl[r].ncyc; c++) begin
                tick(tbl[r].h, tbl[r].p);
                chk($sformatf("tbl%0d_c%0d", r, c), pk(32'(g2), 32'(y2), 32'(r2), w2, 32'(d2)), tbl[r].exp);
            end

        // Three-approach rotation 0 -> 1 -> 2 -> 0.
        for (int k = 0; k < 4; k++) begin
            exp_dir = k % 3;
            chk($sformatf("rot3_%0d", k), (k < q3.size()) ? 32'(q3[k]) : 32'hFFFF_FFFF, 32'(exp_dir));
        end

        // Hold for 5 cycles mid green stretches green to 13 cycles.
        do_reset();
        cnt = 0;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            tick((cnt >= 4 && cnt < 9), 0);
            if (g2[0]) cnt++;
            else if (cnt > 0) done = 1'b1;
        end
        chk("hold_green_len", 32'(cnt), 32'd13);
        for (int k = 0; k < 14; k++) tick(0, 0);

        // Reset mid-yellow; green[0] one cycle after release.
        done = 1'b0;
        for (int k = 0; k < 30 && !done; k++) begin
            tick(0, 0);
            if (y2 != 2'd0) done = 1'b1;
        end
        chk("reach_yellow", 32'(done), 32'd1);
        do_reset();
        tick(0, 0);
        chk("post_rst_green", 32'(g2), 32'd1);

        // Pedestrian request during green[0]: one walk, period 26 (22 without walk).
        do_reset();
        tick(0, 1);
        cyc = 1;
        walks = 0;
        got0 = -1;
        got1 = -1;
        for (int k = 0; k < 60; k++) begin
            tick(0, 0);
            cyc++;
            if (w2) begin
                walks++;
                chk("walk_red", 32'(r2), 32'd3);
            end
            if (g2 == 2'd2 && got1 < 0) got1 = cyc;
            if (got1 > 0 && g2 == 2'd1 && got0 < 0) begin
                got0 = cyc;
                break;
            end
        end
        chk("walk_cycles", 32'(walks), PED ? 32'd4 : 32'd0);
        chk("green1_edge", 32'(got1), PED ? 32'd16 : 32'd12);
        chk("ped_period", 32'(got0 - 1), PED ? 32'd26 : 32'd22);

        // Request on the walk-entry edge is absorbed.
        do_reset();
        tick(0, 1);
        tick(0, 0);
        run_to_allred();
        tick(0, 1);
        count_walks(60, w2 ? 1 : 0, walks);
        chk("absorb_walks", 32'(walks), PED ? 32'd1 : 32'd0);

        // Request during walk re-arms exactly one more walk.
        do_reset();
        tick(0, 1);
        tick(0, 0);
        run_to_allred();
        tick(0, 0);
        cnt = w2 ? 1 : 0;
        tick(0, 1);
        count_walks(60, cnt, walks);
        chk("rearm_walks", 32'(walks), PED ? 32'd2 : 32'd0);

        // Random hold / pedestrian traffic against the model.
        do_reset();
        for (int k = 0; k < 400; k++)
            tick($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
